// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Shares one single-port frame-buffer RAM between display fetches
//            (absolute priority, fixed latency) and a FIFO-buffered writer.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_BIT      = 19,
    parameter int DATA_BIT      = 8,
    parameter int WFIFO_DEPTH   = 4,
    parameter int MEM_LAT       = 1,
    parameter bit WR_BLANK_ONLY = 1'b0
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_blank,
    input  logic                i_disp_req,
    input  logic [ADDR_BIT-1:0] i_disp_addr,
    output logic                o_disp_valid,
    output logic [DATA_BIT-1:0] o_disp_data,
    input  logic                i_wr_valid,
    input  logic [ADDR_BIT-1:0] i_wr_addr,
    input  logic [DATA_BIT-1:0] i_wr_data,
    output logic                o_wr_ready,
    output logic [4:0]          o_wr_count,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_BIT-1:0] o_mem_addr,
    output logic [DATA_BIT-1:0] o_mem_wdata,
    input  logic [DATA_BIT-1:0] i_mem_rdata
);

    localparam int         c_ptr_bit = $clog2(WFIFO_DEPTH);
    localparam logic [4:0] c_depth   = 5'(WFIFO_DEPTH);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_t;

    logic [ADDR_BIT-1:0]  r_fifo_addr [WFIFO_DEPTH];
    logic [DATA_BIT-1:0]  r_fifo_data [WFIFO_DEPTH];
    logic [c_ptr_bit-1:0] r_wr_ptr;
    logic [c_ptr_bit-1:0] r_rd_ptr;
    logic [4:0]           r_count;
    logic [MEM_LAT-1:0]   r_rd_pipe;

    grant_t w_grant;
    logic   w_push;
    logic   w_pop;
    logic   w_wr_allow;
    logic   w_rd_issue;

    assign o_wr_ready = (r_count < c_depth) & ~i_rst;
    assign o_wr_count = r_count;
    assign w_push     = i_wr_valid & o_wr_ready;
    assign w_wr_allow = (WR_BLANK_ONLY == 1'b0) | i_blank;
    assign w_pop      = (w_grant == GNT_WRITE);
    assign w_rd_issue = o_mem_en & ~o_mem_we;

    always_comb begin
        w_grant = GNT_IDLE;
        if (i_disp_req) begin
            w_grant = GNT_DISP;
        end else if ((r_count != 5'd0) && w_wr_allow) begin
            w_grant = GNT_WRITE;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= i_wr_addr;
            r_fifo_data[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (w_grant)
                GNT_DISP: begin
                    o_mem_en   <= 1'b1;
                    o_mem_we   <= 1'b0;
                    o_mem_addr <= i_disp_addr;
                end
                GNT_WRITE: begin
                    o_mem_en    <= 1'b1;
                    o_mem_we    <= 1'b1;
                    o_mem_addr  <= r_fifo_addr[r_rd_ptr];
                    o_mem_wdata <= r_fifo_data[r_rd_ptr];
                end
                default: begin
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0 captures the read command cycle; the last stage lines up with RAM data.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_pipe    <= '0;
            o_disp_valid <= 1'b0;
            o_disp_data  <= '0;
        end else begin
            r_rd_pipe[0] <= w_rd_issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            o_disp_valid <= r_rd_pipe[MEM_LAT-1];
            if (r_rd_pipe[MEM_LAT-1]) begin
                o_disp_data <= i_mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Directed bench for vga_fb_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int ABITS  = 19;
    localparam int DBITS  = 8;
    localparam int DEPTH  = 4;
    localparam int LAT    = 1;
    localparam bit BLANKO = 1'b1;

    logic             clk;
    logic             rst;
    logic             blank;
    logic             disp_req;
    logic [ABITS-1:0] disp_addr;
    logic             disp_valid;
    logic [DBITS-1:0] disp_data;
    logic             wr_valid;
    logic [ABITS-1:0] wr_addr;
    logic [DBITS-1:0] wr_data;
    logic             wr_ready;
    logic [4:0]       wr_count;
    logic             mem_en;
    logic             mem_we;
    logic [ABITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;

    vga_fb_arbiter #(
        .ADDR_BIT      (ABITS),
        .DATA_BIT      (DBITS),
        .WFIFO_DEPTH   (DEPTH),
        .MEM_LAT       (LAT),
        .WR_BLANK_ONLY (BLANKO)
    ) dut (
        .clk          (clk),
        .i_rst        (rst),
        .i_blank      (blank),
        .i_disp_req   (disp_req),
        .i_disp_addr  (disp_addr),
        .o_disp_valid (disp_valid),
        .o_disp_data  (disp_data),
        .i_wr_valid   (wr_valid),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wr_ready   (wr_ready),
        .o_wr_count   (wr_count),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [ABITS-1:0] a;
        logic [DBITS-1:0] d;
    } wr_t;

    typedef struct {
        int               due;
        logic [DBITS-1:0] d;
    } rd_t;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_valid_seen = 0;
    int n_en_seen    = 0;

    logic [DBITS-1:0] ram    [logic [ABITS-1:0]];
    logic [DBITS-1:0] shadow [logic [ABITS-1:0]];
    wr_t wlog [$];
    wr_t wq [$];
    rd_t pend [$];
    int               vq_cyc  [$];
    logic [DBITS-1:0] vq_data [$];

    logic             e_en, e_we, e_valid;
    logic [ABITS-1:0] e_addr;
    logic [DBITS-1:0] e_wdata, e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DBITS-1:0] rd_mem(input logic [ABITS-1:0] a, input bit use_shadow);
        if (use_shadow) return shadow.exists(a) ? shadow[a] : a[DBITS-1:0];
        return ram.exists(a) ? ram[a] : a[DBITS-1:0];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM with one cycle of read latency; initial contents are addr[7:0]
    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) begin
                    ram[mem_addr] = mem_wdata;
                    wlog.push_back('{mem_addr, mem_wdata});
                end else begin
                    mem_rdata <= rd_mem(mem_addr, 1'b0);
                end
            end
        end
    end

    // Compare against the model, then advance the model from this cycle's inputs
    initial begin
        rd_t p;
        wr_t w;
        bit  push;
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_valid = 0; e_data = '0;
        forever begin
            @(negedge clk);
            chk("mem_en",     32'(mem_en),     rst ? 32'd0 : 32'(e_en));
            chk("mem_we",     32'(mem_we),     rst ? 32'd0 : 32'(e_we));
            chk("mem_addr",   32'(mem_addr),   rst ? 32'd0 : 32'(e_addr));
            chk("mem_wdata",  32'(mem_wdata),  rst ? 32'd0 : 32'(e_wdata));
            chk("disp_valid", 32'(disp_valid), rst ? 32'd0 : 32'(e_valid));
            chk("disp_data",  32'(disp_data),  rst ? 32'd0 : 32'(e_data));
            chk("wr_ready",   32'(wr_ready),   32'(!rst && (wq.size() < DEPTH)));
            chk("wr_count",   32'(wr_count),   rst ? 32'd0 : 32'(wq.size()));
            if (disp_valid) begin
                vq_cyc.push_back(cyc);
                vq_data.push_back(disp_data);
                n_valid_seen++;
            end
            if (mem_en) n_en_seen++;

            if (rst) begin
                e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_valid = 0; e_data = '0;
                wq.delete();
                pend.delete();
            end else begin
                if (e_en && e_we) shadow[e_addr] = e_wdata;
                if (e_en && !e_we) begin
                    p.due = cyc + 1 + LAT;
                    p.d   = rd_mem(e_addr, 1'b1);
                    pend.push_back(p);
                end
                if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                    e_valid = 1;
                    e_data  = pend[0].d;
                    void'(pend.pop_front());
                end else begin
                    e_valid = 0;
                end
                push = wr_valid && (wq.size() < DEPTH);
                if (disp_req) begin
                    e_en = 1; e_we = 0; e_addr = disp_addr;
                end else if (wq.size() > 0 && (!BLANKO || blank)) begin
                    w = wq.pop_front();
                    e_en = 1; e_we = 1; e_addr = w.a; e_wdata = w.d;
                end else begin
                    e_en = 0; e_we = 0;
                end
                if (push) wq.push_back('{wr_addr, wr_data});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_wr(input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
        bit done = 0;
        wr_valid = 1; wr_addr = a; wr_data = d;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = wr_ready;
            @(posedge clk);
            #2;
        end
        wr_valid = 0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: got no ready for addr %0h expected ready within 50 cycles", a);
        end
    endtask

    initial begin
        int req0;
        int base;
        int mark_v;
        int mark_e;
        rst = 1; blank = 1; disp_req = 0; disp_addr = '0;
        wr_valid = 0; wr_addr = '0; wr_data = '0;

        // Reset then idle
        step(2);
        @(negedge clk);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_en",    32'(mem_en),   32'd0);
        @(posedge clk); #2;
        rst = 0;
        @(negedge clk);
        chk("rel_ready", 32'(wr_ready), 32'd1);
        chk("rel_count", 32'(wr_count), 32'd0);
        @(posedge clk); #2;

        // Back-to-back reads 0..9
        vq_cyc.delete();
        vq_data.delete();
        req0 = cyc;
        for (int i = 0; i < 10; i++) begin
            disp_req = 1; disp_addr = 19'(i);
            step(1);
        end
        disp_req = 0;
        step(6);
        chk("burst_len", 32'(vq_cyc.size()), 32'd10);
        if (vq_cyc.size() == 10) begin
            chk("burst_first", 32'(vq_cyc[0]), 32'(req0 + 3));
            chk("burst_last",  32'(vq_cyc[9]), 32'(req0 + 12));
            for (int i = 0; i < 10; i++) chk("burst_data", 32'(vq_data[i]), 32'(i));
        end

        // Fill the FIFO under continuous display requests
        base = wlog.size();
        disp_req = 1; disp_addr = 19'h20;
        for (int k = 0; k < 4; k++) push_wr(19'h40 + 19'(k), 8'hA0 + 8'(k));
        wr_valid = 1; wr_addr = 19'h44; wr_data = 8'hA4;
        @(negedge clk);
        chk("full_count", 32'(wr_count), 32'd4);
        chk("full_ready", 32'(wr_ready), 32'd0);
        step(2);
        @(negedge clk);
        chk("held_count", 32'(wr_count), 32'd4);
        @(posedge clk); #2;
        disp_req = 0;
        push_wr(19'h44, 8'hA4);
        step(8);
        chk("fill_nwr", 32'(wlog.size() - base), 32'd5);
        if (wlog.size() - base == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("fill_addr", 32'(wlog[base+k].a), 32'h40 + 32'(k));
                chk("fill_data", 32'(wlog[base+k].d), 32'hA0 + 32'(k));
            end
        end

        // Simultaneous push and pop at count 2
        disp_req = 1; disp_addr = 19'h30;
        wr_valid = 1; wr_addr = 19'h50; wr_data = 8'hB0;
        step(1);
        wr_addr = 19'h51; wr_data = 8'hB1;
        step(1);
        disp_req = 0; wr_addr = 19'h52; wr_data = 8'hB2;
        @(negedge clk);
        chk("pp_count_before", 32'(wr_count), 32'd2);
        @(posedge clk); #2;
        wr_valid = 0;
        @(negedge clk);
        chk("pp_count_after", 32'(wr_count), 32'd2);
        chk("pp_we",          32'(mem_en & mem_we), 32'd1);
        chk("pp_addr",        32'(mem_addr), 32'h50);
        @(posedge clk); #2;
        step(5);

        // Writes held outside blank, then drained interleaved with reads
        blank = 0;
        base = wlog.size();
        for (int k = 0; k < 3; k++) push_wr(19'h60 + 19'(k), 8'hC0 + 8'(k));
        step(4);
        @(negedge clk);
        chk("blank_count", 32'(wr_count), 32'd3);
        chk("blank_nwr",   32'(wlog.size() - base), 32'd0);
        @(posedge clk); #2;
        blank = 1;
        for (int i = 0; i < 6; i++) begin
            disp_req = (i % 2 == 0); disp_addr = 19'h60 + 19'(i / 2);
            step(1);
        end
        disp_req = 0;
        step(6);
        chk("drain_nwr", 32'(wlog.size() - base), 32'd3);
        if (wlog.size() - base == 3) begin
            for (int k = 0; k < 3; k++) chk("drain_addr", 32'(wlog[base+k].a), 32'h60 + 32'(k));
        end

        // Single blank cycle lets exactly one write through
        blank = 0;
        push_wr(19'h70, 8'hD0);
        push_wr(19'h71, 8'hD1);
        blank = 1;
        step(1);
        blank = 0;
        step(3);
        @(negedge clk);
        chk("fall_count", 32'(wr_count), 32'd1);
        chk("fall_last",  32'(wlog[wlog.size()-1].a), 32'h70);
        @(posedge clk); #2;
        blank = 1;
        step(4);

        // Reset with reads in flight and writes queued
        blank = 0;
        for (int k = 0; k < 3; k++) push_wr(19'h80 + 19'(k), 8'hE0 + 8'(k));
        disp_req = 1; disp_addr = 19'h1;
        step(1);
        disp_addr = 19'h2;
        step(1);
        disp_req = 0;
        rst = 1;
        mark_v = n_valid_seen;
        mark_e = n_en_seen;
        step(2);
        rst = 0;
        blank = 1;
        step(6);
        @(negedge clk);
        chk("rst_no_valid", 32'(n_valid_seen - mark_v), 32'd0);
        chk("rst_no_en",    32'(n_en_seen - mark_e),    32'd0);
        chk("rst_count",    32'(wr_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates one single-port frame-buffer RAM between the VGA display fetch path and a pixel writer. Display reads have absolute priority and a fixed latency, so the line buffer never starves. Writer traffic is absorbed by a small write FIFO and drained into cycles the display leaves idle. The block sits between the hsync/vsync timing generators (which produce the display request and address) and the frame-buffer RAM.

## Interface
- ADDR_BIT, 19: frame-buffer address width (640x480 = 307200 pixels).
- DATA_BIT, 8: pixel width.
- WFIFO_DEPTH, 4: write FIFO entries; power of two, 2..16.
- MEM_LAT, 1: RAM read latency in cycles, 1..4.
- WR_BLANK_ONLY, 0: when 1, writes drain only while i_blank=1.

- clk  in  1  system clock; all logic rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_blank  in  1  display outside visible area (from the timing generators).
- i_disp_req  in  1  display pixel fetch request, one per cycle max.
- i_disp_addr  in  ADDR_BIT  fetch address.
- o_disp_valid  out  1  fetched pixel valid.
- o_disp_data  out  DATA_BIT  fetched pixel.
- i_wr_valid  in  1  writer offers a pixel.
- i_wr_addr  in  ADDR_BIT  write address.
- i_wr_data  in  DATA_BIT  write pixel.
- o_wr_ready  out  1  FIFO can accept; a transfer occurs when i_wr_valid & o_wr_ready.
- o_wr_count  out  5  current FIFO occupancy.
- o_mem_en, o_mem_we  out  1 each  RAM command strobe / write enable.
- o_mem_addr  out  ADDR_BIT  RAM address.
- o_mem_wdata  out  DATA_BIT  RAM write data.
- i_mem_rdata  in  DATA_BIT  RAM read data, valid MEM_LAT cycles after command.

## Operation
- Write FIFO: circular buffer of WFIFO_DEPTH {addr,data} entries with a count register. Push on i_wr_valid & o_wr_ready; pop when the arbiter grants a write.
- o_wr_ready = (count < WFIFO_DEPTH) & ~i_rst. Combinational from registered count, so it does not depend on i_wr_valid.
- Simultaneous push and pop when full is not possible, because ready=0. When count is between 1 and DEPTH-1, a simultaneous push and pop leaves the count unchanged.
- Grant is decided each cycle, with priority from highest to lowest:
  1. DISP: i_disp_req=1. Issue a read of i_disp_addr.
  2. WRITE: FIFO non-empty and (WR_BLANK_ONLY=0 or i_blank=1). Issue a write of the head entry and pop it.
  3. IDLE: no command.
- Command registers: o_mem_en/we/addr/wdata are registered from the grant.
  - IDLE drives en=0, we=0, holding addr and wdata.
  - DISP drives we=0 and leaves wdata held.
- Read return: a MEM_LAT-deep valid shift register tracks issued reads. When the tap is 1, i_mem_rdata is registered into o_disp_data and o_disp_valid=1 the next cycle; otherwise o_disp_valid=0 and o_disp_data holds.
- Writes never reorder among themselves (FIFO order). A display read of an address still queued in the FIFO returns the old RAM content; no forwarding.
- The display is never stalled; a write waits indefinitely while the display requests every cycle.

## Timing
- Reset (async assert, sync release): FIFO emptied, count=0, o_wr_count=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_disp_valid=0, o_disp_data=0, valid shift register cleared. o_wr_ready=0 during reset and 1 in the first cycle after release.
- Reset mid-operation: in-flight reads are dropped with no o_disp_valid afterwards, and queued writes are discarded.
- Read latency: request in cycle t → o_mem_en=1, we=0, addr in cycle t+1 → i_mem_rdata in cycle t+1+MEM_LAT → o_disp_valid in cycle t+2+MEM_LAT. This is constant (3 for MEM_LAT=1) and supports back-to-back reads at one per cycle.
- Write path: accept in cycle t → earliest RAM write in cycle t+2. Head is visible to the arbiter in t+1; command is registered for t+2.
- o_wr_count updates one cycle after the push/pop edge.
- WR_BLANK_ONLY=1 with i_blank falling: the write granted in the last blank cycle still issues; no further write issues until i_blank returns to 1.

## Test plan
- Reset then idle:
  - During reset: all outputs at their reset values and o_wr_ready=0.
  - Cycle after release: o_wr_ready=1 and o_wr_count=0.
- Back-to-back reads 0x00000..0x00009 with RAM model data = addr[7:0] (MEM_LAT=1): o_disp_valid high for exactly 10 cycles starting 3 cycles after the first request, with data 0x00..0x09 in order.
- Fill the FIFO with 4 writes while i_disp_req=1 continuously:
  - o_wr_count reaches 4, o_wr_ready=0, and a 5th write is held.
  - After i_disp_req drops, 4 consecutive writes issue in order, and the 5th is then accepted.
- Simultaneous push and pop at count=2, with the display idle: count stays 2, and the RAM sees the head write in the following cycle.
- WR_BLANK_ONLY=1 with i_blank=0:
  - Queued writes do not issue.
  - Raise i_blank: writes drain at one per cycle, interleaved with reads, which win on the same cycle.
- Assert i_rst with 2 reads in flight and 3 writes queued: no o_disp_valid and no o_mem_en after reset, and o_wr_count=0.
